// File: rtl/ast_fifo_pipe.sv
// rtl/ast_fifo_pipe.sv - DEPTH-entry Avalon-ST buffer stage with show-ahead output and fill level.
// Optional sink-side framing monitor enabled by defining PIPE_PKT_CHECK_EN.
module ast_fifo_pipe #(
  parameter int SYMBOLS_PER_BEAT = 3,
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int DEPTH            = 4,
  parameter int WIDTH            = 640,
  parameter int HEIGHT           = 480
) (
  input  logic                                        clock,
  input  logic                                        reset_n,
  input  logic [SYMBOLS_PER_BEAT*BITS_PER_SYMBOL-1:0] din_data,
  input  logic                                        din_valid,
  output logic                                        din_ready,
  input  logic                                        din_startofpacket,
  input  logic                                        din_endofpacket,
  output logic [SYMBOLS_PER_BEAT*BITS_PER_SYMBOL-1:0] dout_data,
  output logic                                        dout_valid,
  input  logic                                        dout_ready,
  output logic                                        dout_startofpacket,
  output logic                                        dout_endofpacket,
  output logic [$clog2(DEPTH):0]                      level
`ifdef PIPE_PKT_CHECK_EN
  ,
  output logic                                        pkt_error
`endif
);

  localparam int DW = SYMBOLS_PER_BEAT * BITS_PER_SYMBOL;
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = DW + 2;

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [EW-1:0] head;
  logic          wr, rd;

  // Ready is decoded from registered level only, so dout_ready never reaches din_ready.
  assign din_ready  = (level_q != LW'(DEPTH));
  assign dout_valid = (level_q != '0);
  assign wr         = din_valid & din_ready;
  assign rd         = dout_valid & dout_ready;
  assign level      = level_q;

  assign head               = mem_q[rd_ptr_q];
  assign dout_data          = dout_valid ? head[DW-1:0] : '0;
  assign dout_startofpacket = dout_valid & head[DW];
  assign dout_endofpacket   = dout_valid & head[DW+1];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr) begin
      mem_d[wr_ptr_q] = {din_endofpacket, din_startofpacket, din_data};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (rd) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({wr, rd})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

`ifdef PIPE_PKT_CHECK_EN
  localparam int FRAME = WIDTH * HEIGHT;
  localparam int CW    = $clog2(FRAME) + 1;

  logic          in_pkt_q, in_pkt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          len_bad;

  // Count includes the current beat; compared one bit wider so saturation cannot alias.
  assign len_bad   = ({1'b0, cnt_q} + 1'b1) != (CW+1)'(FRAME);
  assign pkt_error = err_q;

  always_comb begin
    in_pkt_d = in_pkt_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    if (wr) begin
      if (din_startofpacket) begin
        if (in_pkt_q) err_d = 1'b1;
        if (din_endofpacket) begin
          if (FRAME != 1) err_d = 1'b1;
          in_pkt_d = 1'b0;
          cnt_d    = '0;
        end else begin
          in_pkt_d = 1'b1;
          cnt_d    = CW'(1);
        end
      end else if (!in_pkt_q) begin
        err_d = 1'b1;
      end else if (din_endofpacket) begin
        if (len_bad) err_d = 1'b1;
        in_pkt_d = 1'b0;
        cnt_d    = '0;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in_pkt_q <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      in_pkt_q <= in_pkt_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_ast_fifo_pipe.sv
// tb/tb_ast_fifo_pipe.sv - directed self-checking bench for ast_fifo_pipe (DEPTH=4, WIDTH=4, HEIGHT=2).
// Framing checks run when PIPE_PKT_CHECK_EN is defined.
module tb_ast_fifo_pipe;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [23:0] din_data;
  logic        din_valid;
  logic        din_ready;
  logic        din_startofpacket;
  logic        din_endofpacket;
  logic [23:0] dout_data;
  logic        dout_valid;
  logic        dout_ready;
  logic        dout_startofpacket;
  logic        dout_endofpacket;
  logic [2:0]  level;
`ifdef PIPE_PKT_CHECK_EN
  logic        pkt_error;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  ast_fifo_pipe #(
    .SYMBOLS_PER_BEAT(3),
    .BITS_PER_SYMBOL (8),
    .DEPTH           (4),
    .WIDTH           (4),
    .HEIGHT          (2)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .din_data          (din_data),
    .din_valid         (din_valid),
    .din_ready         (din_ready),
    .din_startofpacket (din_startofpacket),
    .din_endofpacket   (din_endofpacket),
    .dout_data         (dout_data),
    .dout_valid        (dout_valid),
    .dout_ready        (dout_ready),
    .dout_startofpacket(dout_startofpacket),
    .dout_endofpacket  (dout_endofpacket),
    .level             (level)
`ifdef PIPE_PKT_CHECK_EN
    ,
    .pkt_error         (pkt_error)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_beat(input logic [23:0] d, input logic s, input logic e);
    logic acc;
    acc = 1'b0;
    din_valid = 1'b1;
    din_data = d;
    din_startofpacket = s;
    din_endofpacket = e;
    for (int t = 0; t < 50 && !acc; t++) begin
      acc = din_ready;
      tick();
    end
    din_valid = 1'b0;
    if (!acc) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_pkt(input int n, input logic [23:0] base);
    for (int i = 0; i < n; i++) send_beat(base + 24'(i), i == 0, i == n - 1);
  endtask

  logic [25:0] sb[$];
  logic [25:0] exp_beat;
  int          sent, rcvd;

  initial begin
    reset_n = 1'b0;
    din_data = '0;
    din_valid = 1'b0;
    din_startofpacket = 1'b0;
    din_endofpacket = 1'b0;
    dout_ready = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // 1: reset state
    check("rst_level", 32'(level), 32'd0);
    check("rst_dout_valid", 32'(dout_valid), 32'd0);
    check("rst_din_ready", 32'(din_ready), 32'd1);
    check("rst_dout_data", 32'(dout_data), 32'h0);

    // 2: fill then drain in order
    for (int i = 1; i <= 4; i++) begin
      din_valid = 1'b1;
      din_data = 24'(i);
      tick();
    end
    din_valid = 1'b0;
    check("fill_level", 32'(level), 32'd4);
    check("fill_din_ready", 32'(din_ready), 32'd0);
    dout_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_valid", 32'(dout_valid), 32'd1);
      check("drain_data", 32'(dout_data), 32'(i));
      tick();
    end
    dout_ready = 1'b0;
    check("drain_level", 32'(level), 32'd0);
    check("drain_dout_valid", 32'(dout_valid), 32'd0);
    check("drain_dout_data", 32'(dout_data), 32'h0);

    // 3: streaming at one beat per clock
    dout_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      din_valid = 1'b1;
      din_data = 24'h100 + 24'(i);
      if (i > 0) begin
        check("stream_level", 32'(level), 32'd1);
        check("stream_data", 32'(dout_data), 32'h100 + 32'(i - 1));
      end
      tick();
    end
    din_valid = 1'b0;
    check("stream_last", 32'(dout_data), 32'h10f);
    tick();
    check("stream_empty", 32'(level), 32'd0);
    dout_ready = 1'b0;

    // 4: full with simultaneous read attempt and write attempt
    for (int i = 0; i < 4; i++) begin
      din_valid = 1'b1;
      din_data = 24'h200 + 24'(i);
      tick();
    end
    din_data = 24'h2ff;
    dout_ready = 1'b1;
    check("full_din_ready", 32'(din_ready), 32'd0);
    check("full_head", 32'(dout_data), 32'h200);
    tick();
    din_valid = 1'b0;
    check("full_level_after", 32'(level), 32'd3);
    check("full_ready_after", 32'(din_ready), 32'd1);
    for (int i = 1; i < 4; i++) begin
      check("full_drain", 32'(dout_data), 32'h200 + 32'(i));
      tick();
    end
    check("full_no_write", 32'(level), 32'd0);
    dout_ready = 1'b0;

    // 5: random traffic against a scoreboard
    sent = 0;
    rcvd = 0;
    for (int cyc = 0; cyc < 20000 && rcvd < 1000; cyc++) begin
      din_valid = (sent < 1000) && ($urandom_range(0, 1) == 1);
      din_data = 24'($urandom);
      din_startofpacket = 1'($urandom);
      din_endofpacket = 1'($urandom);
      dout_ready = 1'($urandom);
      if (level > 3'd4) check("rand_level_range", 32'(level), 32'd4);
      if (din_valid && din_ready) begin
        sb.push_back({din_endofpacket, din_startofpacket, din_data});
        sent++;
      end
      if (dout_valid && dout_ready) begin
        exp_beat = (sb.size() > 0) ? sb.pop_front() : 26'h3ffffff;
        check("rand_beat", 32'({dout_endofpacket, dout_startofpacket, dout_data}), 32'(exp_beat));
        rcvd++;
      end
      tick();
    end
    din_valid = 1'b0;
    din_startofpacket = 1'b0;
    din_endofpacket = 1'b0;
    dout_ready = 1'b0;
    check("rand_count", 32'(rcvd), 32'd1000);
    check("rand_level_end", 32'(level), 32'd0);

    // Reset mid-operation discards held beats
    din_valid = 1'b1;
    din_data = 24'h300;
    tick(); tick();
    din_valid = 1'b0;
    check("mid_level_pre", 32'(level), 32'd2);
    reset_n = 1'b0;
    #1;
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_valid", 32'(dout_valid), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("mid_rst_no_replay", 32'(dout_valid), 32'd0);

`ifdef PIPE_PKT_CHECK_EN
    // 6: framing monitor
    dout_ready = 1'b1;
    check("pkt_rst", 32'(pkt_error), 32'd0);
    send_pkt(8, 24'h400);
    check("pkt_good", 32'(pkt_error), 32'd0);
    send_pkt(7, 24'h500);
    check("pkt_short", 32'(pkt_error), 32'd1);
    send_pkt(8, 24'h600);
    check("pkt_sticky", 32'(pkt_error), 32'd1);
    dout_ready = 1'b0;
    send_beat(24'h700, 1'b1, 1'b0);
    send_beat(24'h701, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    check("pkt_mid_rst_level", 32'(level), 32'd0);
    check("pkt_mid_rst_err", 32'(pkt_error), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
